// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce bank.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    HELD      = 3'd2,
    LONG      = 3'd3,
    REL_CHK   = 3'd4
  } key_state_t;

  // Per-channel registered outputs: debounced level plus three one-cycle strobes.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic hold;
  } key_evt_t;

  localparam int unsigned KEY_MAX_CHANNELS = 32;
  localparam int unsigned KEY_SYNC_STAGES  = 2;

  function automatic int unsigned ms2cyc(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold max_cyc without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_cyc);
    int unsigned w;
    w = $clog2(max_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-FF synchroniser, debounce counter, press/hold/release FSM.
// Auto-repeat in the LONG state exists only when KEY_REPEAT_EN is defined.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 5,
  parameter int unsigned LONG_CYC = 20,
`ifdef KEY_REPEAT_EN
  parameter int unsigned REP_CYC  = 4,
`endif
  parameter int unsigned CW       = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     keyin,
  output key_evt_t evt
);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
`endif

  logic          sync1;
  logic          sync2;
  logic          sk;
  key_state_t    state;
  key_state_t    ret_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // Sync chain resets to released (pins are active low).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= keyin;
      sync2 <= sync1;
    end
  end

  assign sk      = ~sync2;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ret_state <= HELD;
      cnt       <= '0;
      evt       <= '0;
    end else begin
      evt.press <= 1'b0;
      evt.rel   <= 1'b0;
      evt.hold  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sk) begin
            state <= PRESS_CHK;
            cnt   <= CW'(1);
          end
        end

        PRESS_CHK: begin
          if (!sk) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            evt.level <= 1'b1;
            evt.press <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        HELD: begin
          if (!sk) begin
            state     <= REL_CHK;
            ret_state <= HELD;
            cnt       <= CW'(1);
          end else if (cnt >= LONG_LAST) begin
            state    <= LONG;
            cnt      <= '0;
            evt.hold <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        LONG: begin
          if (!sk) begin
            state     <= REL_CHK;
            ret_state <= LONG;
            cnt       <= CW'(1);
`ifdef KEY_REPEAT_EN
          end else if (cnt >= REP_LAST) begin
            cnt      <= '0;
            evt.hold <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
`else
          end else begin
            cnt <= '0;
          end
`endif
        end

        // A bounce back to pressed resumes the previous hold phase with a fresh count.
        REL_CHK: begin
          if (sk) begin
            state <= ret_state;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            evt.level <= 1'b0;
            evt.rel   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          evt.level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_array.sv
// N-channel active-low key front end: per-channel debounce with level and event strobes.
// Define KEY_REPEAT_EN to add auto-repeat of long_pulse while a key stays held.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS    = 4,
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned DEB_MS    = 20,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keyin,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse
);

  localparam int unsigned DEB_CYC  = ms2cyc(CLK_HZ, DEB_MS);
  localparam int unsigned LONG_CYC = ms2cyc(CLK_HZ, LONG_MS);
  localparam int unsigned REP_CYC  = ms2cyc(CLK_HZ, REPEAT_MS);
`ifdef KEY_REPEAT_EN
  localparam int unsigned CW = cnt_width(max2(max2(DEB_CYC, LONG_CYC), REP_CYC));
`else
  localparam int unsigned CW = cnt_width(max2(DEB_CYC, LONG_CYC));
`endif

  // Elaboration-time sanity checks on the derived cycle counts.
  if (N_KEYS < 1 || N_KEYS > KEY_MAX_CHANNELS) begin : g_bad_n
    $error("key_debounce_array: N_KEYS out of range");
  end
  if (DEB_CYC < 2 || LONG_CYC < 2) begin : g_bad_cyc
    $error("key_debounce_array: debounce/long periods too short for CLK_HZ");
  end
  if (REP_CYC < 2) begin : g_bad_rep
    $error("key_debounce_array: repeat period too short for CLK_HZ");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_evt_t evt;

    key_chan #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC),
`ifdef KEY_REPEAT_EN
      .REP_CYC  (REP_CYC),
`endif
      .CW       (CW)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .keyin (keyin[i]),
      .evt   (evt)
    );

    assign key_level[i]     = evt.level;
    assign press_pulse[i]   = evt.press;
    assign release_pulse[i] = evt.rel;
    assign long_pulse[i]    = evt.hold;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed scoreboard bench for key_debounce_array (5/20/4-cycle configuration).
// Honours KEY_REPEAT_EN when predicting long_pulse repeats.
module tb_key_debounce_array;

  localparam int N    = 4;
  localparam int DEB  = 5;
  localparam int LNG  = 20;
  localparam int REP  = 4;
  localparam int LAT  = 2 + DEB;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] keyin = '0;
  logic [N-1:0] key_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t q[$];

  key_debounce_array #(
    .N_KEYS    (N),
    .CLK_HZ    (1000),
    .DEB_MS    (DEB),
    .LONG_MS   (LNG),
    .REPEAT_MS (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .keyin         (keyin),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int c, input int k, input int ch);
    return c * 16 + k * 4 + ch;
  endfunction

  task automatic push(input int c, input int k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard: every strobe observed must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    logic b;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missing_event", 32'hFFFF_FFFF, enc(e.cyc, e.kind, e.ch));
    end
    for (int ch = 0; ch < N; ch++) begin
      for (int k = 0; k < 3; k++) begin
        b = (k == K_PRESS) ? press_pulse[ch] : (k == K_REL) ? release_pulse[ch] : long_pulse[ch];
        if (b === 1'b1) begin
          if (q.size() == 0) begin
            check("unexpected_event", enc(cyc, k, ch), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("event", enc(cyc, k, ch), enc(e.cyc, e.kind, e.ch));
          end
        end
      end
    end
  end

  initial begin
    int c;
    int g;
    int p;

    // Reset with all keys held.
    rst   = 1'b0;
    keyin = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_level", key_level, 0);
    check("rst_pulses", {press_pulse, release_pulse, long_pulse}, 0);

    c   = cyc;
    rst = 1'b1;
    for (int ch = 0; ch < N; ch++) push(c + LAT, K_PRESS, ch);
    wait_to(c + LAT - 1);
    check("t1_level_before", key_level, 0);
    wait_to(c + LAT);
    check("t1_level_all", key_level, 4'hF);
    wait_to(c + LAT + 2);
    c     = cyc;
    keyin = 4'hF;
    for (int ch = 0; ch < N; ch++) push(c + LAT, K_REL, ch);
    wait_to(c + LAT - 1);
    check("t1_level_held", key_level, 4'hF);
    wait_to(c + LAT);
    check("t1_level_rel", key_level, 0);
    wait_to(c + LAT + 5);

    // Bounce on ch0: two 3-cycle lows never qualify.
    c        = cyc;
    keyin[0] = 1'b0;
    wait_to(c + 3);
    keyin[0] = 1'b1;
    wait_to(c + 5);
    keyin[0] = 1'b0;
    wait_to(c + 8);
    keyin[0] = 1'b1;
    wait_to(c + 15);
    check("t2_level0", key_level[0], 0);

    // Clean press/release on ch1.
    c        = cyc;
    keyin[1] = 1'b0;
    push(c + LAT, K_PRESS, 1);
    wait_to(c + LAT);
    check("t3_level_on", key_level, 4'b0010);
    wait_to(c + 10);
    keyin[1] = 1'b1;
    push(c + 10 + LAT, K_REL, 1);
    wait_to(c + 10 + LAT - 1);
    check("t3_level_hold", key_level[1], 1);
    wait_to(c + 10 + LAT);
    check("t3_level_off", key_level[1], 0);
    wait_to(c + 25);

    // 60-cycle hold on ch2: long_pulse 20 cycles after press, repeats if enabled.
    c        = cyc;
    keyin[2] = 1'b0;
    push(c + LAT, K_PRESS, 2);
    push(c + LAT + LNG, K_LONG, 2);
`ifdef KEY_REPEAT_EN
    for (int t = c + LAT + LNG + REP; t < c + 60 + 3; t += REP) push(t, K_LONG, 2);
`endif
    wait_to(c + 60);
    check("t4_level_held", key_level, 4'b0100);
    keyin[2] = 1'b1;
    push(c + 60 + LAT, K_REL, 2);
    wait_to(c + 60 + LAT + 3);
    check("t4_level_off", key_level[2], 0);

    // Release glitch on ch3: 2-cycle high blip is absorbed.
    c        = cyc;
    keyin[3] = 1'b0;
    push(c + LAT, K_PRESS, 3);
    wait_to(c + 10);
    g        = cyc;
    keyin[3] = 1'b1;
    wait_to(g + 2);
    keyin[3] = 1'b0;
    wait_to(g + 8);
    check("t5_level_kept", key_level[3], 1);
    wait_to(g + 12);
    keyin[3] = 1'b1;
    push(g + 12 + LAT, K_REL, 3);
    wait_to(g + 12 + LAT + 1);
    check("t5_level_off", key_level[3], 0);
    wait_to(cyc + 5);

    // Reset while ch0 sits in LONG; the key must be re-debounced afterwards.
    c        = cyc;
    keyin[0] = 1'b0;
    push(c + LAT, K_PRESS, 0);
    push(c + LAT + LNG, K_LONG, 0);
    wait_to(c + LAT + LNG + 2);
    check("t6_level_pre", key_level[0], 1);
    rst = 1'b0;
    #1;
    check("t6_rst_level", key_level, 0);
    check("t6_rst_pulses", {press_pulse, release_pulse, long_pulse}, 0);
    @(negedge clk);
    rst = 1'b1;
    p   = cyc + LAT;
    push(p, K_PRESS, 0);
    push(p + LNG, K_LONG, 0);
    wait_to(p - 1);
    check("t6_level_redeb", key_level[0], 0);
    wait_to(p + LNG);
    check("t6_level_long", key_level[0], 1);
    wait_to(p + LNG + 1);
    keyin[0] = 1'b1;
    push(p + LNG + 1 + LAT, K_REL, 0);
    wait_to(p + LNG + 1 + LAT + 10);
    check("final_level", key_level, 0);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
